score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 28 ++
 rtl/score_keeper.sv | 117 +++++++++++
 tb/tb_score_keeper.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Control strobes and scoreboard outputs of the rhythm-game score keeper.
// The game side is the master; the score keeper is the slave.
interface score_keeper_if;
    logic        game_start;
    logic        game_over;
    logic        hit_valid;
    logic [1:0]  grade;
    logic        miss_pulse;
    logic        playing;
    logic [15:0] score_bcd;
    logic [7:0]  combo_bcd;
    logic [7:0]  max_combo_bcd;
    logic [7:0]  perfect_cnt;
    logic [7:0]  good_cnt;
    logic [7:0]  miss_cnt;

    modport master (
        output game_start, game_over, hit_valid, grade, miss_pulse,
        input  playing, score_bcd, combo_bcd, max_combo_bcd,
               perfect_cnt, good_cnt, miss_cnt
    );

    modport slave (
        input  game_start, game_over, hit_valid, grade, miss_pulse,
        output playing, score_bcd, combo_bcd, max_combo_bcd,
               perfect_cnt, good_cnt, miss_cnt
    );
endinterface

// File: rtl/score_keeper.sv
// Rhythm-game scoreboard: BCD score with combo bonus, BCD combo/max combo,
// saturating hit/miss counters, and an IDLE/PLAY/DONE game FSM.
module score_keeper #(
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1,
    parameter int COMBO_TH    = 10
) (
    input logic          clk,
    input logic          rst_n,
    score_keeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    state_t state;

    // Decimal add of a small point value; any carry out of the top digit saturates.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] pts);
        logic [15:0] r;
        logic [4:0]  d;
        logic [4:0]  carry;
        r     = '0;
        carry = {1'b0, pts};
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, s[i*4 +: 4]} + carry;
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                carry       = 5'd1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                carry       = 5'd0;
            end
        end
        if (carry != 5'd0) r = 16'h9999;
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] c);
        if (c == 8'h99)          return c;
        else if (c[3:0] == 4'd9) return {c[7:4] + 4'd1, 4'd0};
        else                     return {c[7:4], c[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] c, input logic [1:0] n);
        logic [8:0] t;
        t = {1'b0, c} + {7'd0, n};
        return (t > 9'd255) ? 8'hFF : t[7:0];
    endfunction

    logic        perfect_hit;
    logic        good_hit;
    logic        bonus;
    logic [6:0]  combo_bin;
    logic [3:0]  pts;
    logic [1:0]  miss_inc;
    logic [7:0]  combo_nxt;
    logic [7:0]  max_nxt;
    logic [15:0] score_nxt;

    always_comb begin
        perfect_hit = bus.hit_valid && (bus.grade == 2'b11);
        good_hit    = bus.hit_valid && (bus.grade == 2'b10 || bus.grade == 2'b01);
        combo_bin   = 7'(bus.combo_bcd[7:4]) * 7'd10 + 7'(bus.combo_bcd[3:0]);
        bonus       = (combo_bin >= 7'(COMBO_TH));
        pts         = 4'd0;
        if (perfect_hit)   pts = 4'(PERFECT_PTS) + {3'd0, bonus};
        else if (good_hit) pts = 4'(GOOD_PTS);
        // A miss in the same cycle as a hit wins over the combo increment.
        miss_inc  = 2'(bus.hit_valid && (bus.grade == 2'b00)) + 2'(bus.miss_pulse);
        combo_nxt = bus.combo_bcd;
        if (miss_inc != 2'd0)             combo_nxt = 8'h00;
        else if (perfect_hit || good_hit) combo_nxt = bcd_inc_sat(bus.combo_bcd);
        max_nxt   = (combo_nxt > bus.max_combo_bcd) ? combo_nxt : bus.max_combo_bcd;
        score_nxt = bcd_add_sat(bus.score_bcd, pts);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            bus.playing       <= 1'b0;
            bus.score_bcd     <= '0;
            bus.combo_bcd     <= '0;
            bus.max_combo_bcd <= '0;
            bus.perfect_cnt   <= '0;
            bus.good_cnt      <= '0;
            bus.miss_cnt      <= '0;
        end else if (bus.game_start) begin
            // Start or restart from any state, overriding a same-cycle game_over.
            state             <= PLAY;
            bus.playing       <= 1'b1;
            bus.score_bcd     <= '0;
            bus.combo_bcd     <= '0;
            bus.max_combo_bcd <= '0;
            bus.perfect_cnt   <= '0;
            bus.good_cnt      <= '0;
            bus.miss_cnt      <= '0;
        end else begin
            case (state)
                PLAY: begin
                    bus.score_bcd     <= score_nxt;
                    bus.combo_bcd     <= combo_nxt;
                    bus.max_combo_bcd <= max_nxt;
                    bus.perfect_cnt   <= sat_add8(bus.perfect_cnt, {1'b0, perfect_hit});
                    bus.good_cnt      <= sat_add8(bus.good_cnt, {1'b0, good_hit});
                    bus.miss_cnt      <= sat_add8(bus.miss_cnt, miss_inc);
                    if (bus.game_over) begin
                        state       <= DONE;
                        bus.playing <= 1'b0;
                    end
                end
                IDLE, DONE: ;
                default: begin
                    state       <= IDLE;
                    bus.playing <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: an integer-arithmetic game model checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_score_keeper;
    localparam int PERF = 3;
    localparam int GOOD = 1;
    localparam int TH   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    score_keeper_if bus();

    score_keeper #(.PERFECT_PTS(PERF), .GOOD_PTS(GOOD), .COMBO_TH(TH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    // Model: 0 idle, 1 play, 2 done
    int m_state, m_score, m_combo, m_max, m_perf, m_good, m_miss;

    function automatic logic [15:0] to_bcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_combo = 0; m_max = 0;
        m_perf = 0; m_good = 0; m_miss = 0;
    endtask

    task automatic model_step();
        int pts, misses;
        bit up;
        if (!rst_n) return;
        if (bus.game_start) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1) begin
            pts = 0; misses = 0; up = 0;
            if (bus.hit_valid) begin
                if (bus.grade == 2'b11) begin
                    pts = PERF + ((m_combo >= TH) ? 1 : 0);
                    up = 1; m_perf = min_i(m_perf + 1, 255);
                end else if (bus.grade != 2'b00) begin
                    pts = GOOD; up = 1; m_good = min_i(m_good + 1, 255);
                end else misses++;
            end
            if (bus.miss_pulse) misses++;
            m_score = min_i(m_score + pts, 9999);
            if (misses > 0) m_combo = 0;
            else if (up)    m_combo = min_i(m_combo + 1, 99);
            if (m_combo > m_max) m_max = m_combo;
            m_miss = min_i(m_miss + misses, 255);
            if (bus.game_over) m_state = 2;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("playing", 16'(bus.playing), 16'(m_state == 1));
            chk("score", bus.score_bcd, to_bcd16(m_score));
            chk("combo", 16'(bus.combo_bcd), 16'(to_bcd8(m_combo)));
            chk("max_combo", 16'(bus.max_combo_bcd), 16'(to_bcd8(m_max)));
            chk("perfect_cnt", 16'(bus.perfect_cnt), 16'(m_perf));
            chk("good_cnt", 16'(bus.good_cnt), 16'(m_good));
            chk("miss_cnt", 16'(bus.miss_cnt), 16'(m_miss));
        end
    end

    task automatic drive(input logic gs, input logic go, input logic hv,
                         input logic [1:0] gr, input logic mp);
        bus.game_start = gs; bus.game_over = go; bus.hit_valid = hv;
        bus.grade = gr; bus.miss_pulse = mp;
        @(posedge clk);
        model_step();
        #1;
        bus.game_start = 0; bus.game_over = 0; bus.hit_valid = 0;
        bus.grade = 2'b00; bus.miss_pulse = 0;
        @(negedge clk);
    endtask

    task automatic perfect(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, 2'b11, 0);
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        #1 chk(name, act, exp);
    endtask

    initial begin
        bus.game_start = 0; bus.game_over = 0; bus.hit_valid = 0;
        bus.grade = 2'b00; bus.miss_pulse = 0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        lit("reset_score", bus.score_bcd, 16'h0000);
        lit("reset_playing", 16'(bus.playing), 16'h0000);

        // Strobes in IDLE are ignored
        drive(0, 0, 1, 2'b11, 0);
        drive(0, 0, 0, 2'b00, 1);
        lit("idle_ignore", bus.score_bcd, 16'h0000);

        // Three perfects
        drive(1, 0, 0, 2'b00, 0);
        lit("start_playing", 16'(bus.playing), 16'h0001);
        perfect(3);
        lit("p3_score", bus.score_bcd, 16'h0009);
        lit("p3_combo", 16'(bus.combo_bcd), 16'h0003);
        lit("p3_perf", 16'(bus.perfect_cnt), 16'h0003);
        lit("p3_max", 16'(bus.max_combo_bcd), 16'h0003);

        // Combo bonus kicks in once combo reaches the threshold
        drive(1, 0, 0, 2'b00, 0);
        perfect(10);
        lit("c10_score", bus.score_bcd, 16'h0030);
        perfect(1);
        lit("c11_score", bus.score_bcd, 16'h0034);
        lit("c11_combo", 16'(bus.combo_bcd), 16'h0011);

        // Miss clears combo; simultaneous early hit and miss
        drive(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 2'b01, 0);
        drive(0, 0, 0, 2'b00, 1);
        lit("miss_combo", 16'(bus.combo_bcd), 16'h0000);
        lit("miss_max", 16'(bus.max_combo_bcd), 16'h0005);
        lit("miss_cnt1", 16'(bus.miss_cnt), 16'h0001);
        drive(0, 0, 1, 2'b01, 1);
        lit("both_score", bus.score_bcd, 16'h0006);
        lit("both_good", 16'(bus.good_cnt), 16'h0006);
        lit("both_miss", 16'(bus.miss_cnt), 16'h0002);
        drive(0, 0, 1, 2'b10, 0);
        drive(0, 0, 1, 2'b00, 0);
        lit("grade0_combo", 16'(bus.combo_bcd), 16'h0000);

        // 0099 -> 0100 carry
        drive(1, 0, 0, 2'b00, 0);
        for (int b = 0; b < 3; b++) begin
            perfect(10);
            drive(0, 0, 0, 2'b00, 1);
        end
        perfect(3);
        lit("s99", bus.score_bcd, 16'h0099);
        drive(0, 0, 1, 2'b10, 0);
        lit("s100", bus.score_bcd, 16'h0100);

        // Saturation: score 9999, combo 99, perfect_cnt 255
        drive(1, 0, 0, 2'b00, 0);
        perfect(10 + 2491);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 2'b01, 0);
        lit("s9997", bus.score_bcd, 16'h9997);
        perfect(2);
        lit("sat_score", bus.score_bcd, 16'h9999);
        lit("sat_combo", 16'(bus.combo_bcd), 16'h0099);
        lit("sat_max", 16'(bus.max_combo_bcd), 16'h0099);
        lit("sat_perf", 16'(bus.perfect_cnt), 16'h00FF);

        // game_over freezes everything
        drive(0, 1, 0, 2'b00, 0);
        drive(0, 0, 1, 2'b11, 0);
        drive(0, 0, 0, 2'b00, 1);
        drive(0, 1, 0, 2'b00, 0);
        lit("done_playing", 16'(bus.playing), 16'h0000);
        lit("done_score", bus.score_bcd, 16'h9999);
        lit("done_miss", 16'(bus.miss_cnt), 16'h0000);
        drive(1, 0, 0, 2'b00, 0);
        lit("restart_score", bus.score_bcd, 16'h0000);
        lit("restart_playing", 16'(bus.playing), 16'h0001);

        // game_start beats game_over
        perfect(2);
        drive(1, 1, 0, 2'b00, 0);
        lit("start_wins", 16'(bus.playing), 16'h0001);
        lit("start_wins_score", bus.score_bcd, 16'h0000);

        // Asynchronous reset mid-game
        perfect(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("arst_score", bus.score_bcd, 16'h0000);
        chk("arst_playing", 16'(bus.playing), 16'h0000);
        @(negedge clk);
        drive(0, 0, 1, 2'b11, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 1, 2'b11, 0);
        drive(0, 0, 0, 2'b00, 1);
        lit("post_rst_ignore", bus.score_bcd, 16'h0000);
        drive(1, 0, 0, 2'b00, 0);
        perfect(1);
        lit("post_rst_play", bus.score_bcd, 16'h0003);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
